// File: rtl/conv_post_process_pkg.sv
// Shared conv-unit constants: default lane widths, config field widths, int8 limits.
// Latency: none (package only).
// Backpressure: not applicable.
package conv_post_process_pkg;

  localparam int CONV_OUT_NUM_DEF = 18;
  localparam int PSUM_WIDTH_DEF   = 24;
  localparam int ACC_WIDTH_DEF    = 32;
  localparam int BIAS_WIDTH_DEF   = 16;
  localparam int DATA_WIDTH_DEF   = 8;
  localparam int CNT_WIDTH_DEF    = 9;

  localparam int PASS_WIDTH  = 4;
  localparam int SHIFT_WIDTH = 5;

  // int8 activation saturation limits
  localparam int DATA_MAX = 127;
  localparam int DATA_MIN = -128;

  // A pass count of zero is treated as a single pass.
  function automatic logic [PASS_WIDTH-1:0] eff_pass(input logic [PASS_WIDTH-1:0] pn);
    return (pn == '0) ? PASS_WIDTH'(1) : pn;
  endfunction

endpackage

// File: rtl/conv_post_process_if.sv
// Partial-sum input beats and requantised activation output of the post-process block.
// Latency: none (wires only).
// Backpressure: none; the output side has no ready, so the sink must always accept.
//   master: drives psum_in/valid_in, observes data_out/valid_out/eol_out/eof_out
//   slave : the post-process block
interface conv_post_process_if #(
  parameter int CONV_OUT_NUM = 18,
  parameter int PSUM_WIDTH   = 24,
  parameter int DATA_WIDTH   = 8
);
  logic [CONV_OUT_NUM*PSUM_WIDTH-1:0] psum_in;
  logic                               valid_in;
  logic [CONV_OUT_NUM*DATA_WIDTH-1:0] data_out;
  logic                               valid_out;
  logic                               eol_out;
  logic                               eof_out;

  modport master (output psum_in, valid_in, input data_out, valid_out, eol_out, eof_out);
  modport slave  (input psum_in, valid_in, output data_out, valid_out, eol_out, eof_out);
endinterface

// File: rtl/conv_requant_lane.sv
// One output lane: bias add (stage 2), then round / shift / ReLU / int8 saturate (stage 3).
// Latency: 2 cycles from s2_en to dat update.
// Backpressure: none; each stage captures whenever its enable is high.
//   s2_en/acc/bias: capture final accumulator plus bias; s3_en/shift/relu_en: requantise
//   dat: registered int8 result
module conv_requant_lane
  import conv_post_process_pkg::*;
#(
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int BIAS_WIDTH = BIAS_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          s2_en,
  input  logic                          s3_en,
  input  logic signed [ACC_WIDTH-1:0]   acc,
  input  logic signed [BIAS_WIDTH-1:0]  bias,
  input  logic [SHIFT_WIDTH-1:0]        shift,
  input  logic                          relu_en,
  output logic [DATA_WIDTH-1:0]         dat
);

  // Two guard bits: one for the bias add, one for the rounding offset.
  localparam int SW = ACC_WIDTH + 2;

  logic signed [SW-1:0]   biased;
  logic signed [SW-1:0]   rounded;
  logic signed [SW-1:0]   shifted;
  logic signed [SW-1:0]   sat_lo;
  logic [DATA_WIDTH-1:0]  dat_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      biased <= '0;
    else if (s2_en) biased <= SW'(acc) + SW'(bias);
  end

  always_comb begin
    rounded = biased;
    if (shift != '0) rounded = biased + (SW'(1) << (shift - SHIFT_WIDTH'(1)));
    shifted = rounded >>> shift;
    sat_lo  = relu_en ? '0 : SW'(DATA_MIN);
    if (shifted > SW'(DATA_MAX))  dat_nxt = DATA_WIDTH'(DATA_MAX);
    else if (shifted < sat_lo)    dat_nxt = DATA_WIDTH'(sat_lo);
    else                          dat_nxt = shifted[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      dat <= '0;
    else if (s3_en) dat <= dat_nxt;
  end

endmodule

// File: rtl/conv_post_process.sv
// Accumulates multi-pass partial sums per pixel, adds bias, requantises to int8, tags eol/eof.
// Latency: valid_out 3 cycles after the final-beat valid_in; one output per pixel.
// Backpressure: none; back-to-back pixels give back-to-back valid_out.
//   bus (slave): psum_in/valid_in in, data_out/valid_out/eol_out/eof_out out
//   bias_in/pass_num/shift/relu_en/col_len/row_len: layer config; cfg_rst: sync clear
module conv_post_process
  import conv_post_process_pkg::*;
#(
  parameter int CONV_OUT_NUM = CONV_OUT_NUM_DEF,
  parameter int PSUM_WIDTH   = PSUM_WIDTH_DEF,
  parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
  parameter int BIAS_WIDTH   = BIAS_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                               clk,
  input  logic                               rstn,
  conv_post_process_if.slave                 bus,
  input  logic [CONV_OUT_NUM*BIAS_WIDTH-1:0] bias_in,
  input  logic [PASS_WIDTH-1:0]              pass_num,
  input  logic [SHIFT_WIDTH-1:0]             shift,
  input  logic                               relu_en,
  input  logic [CNT_WIDTH-1:0]               col_len,
  input  logic [CNT_WIDTH-1:0]               row_len,
  input  logic                               cfg_rst
);

  logic [PASS_WIDTH-1:0] beat_cnt;
  logic [PASS_WIDTH-1:0] pass_eff;
  logic                  first_beat;
  logic                  last_beat;
  logic                  s1_vld;
  logic                  s2_vld;
  logic [CNT_WIDTH-1:0]  col_cnt;
  logic [CNT_WIDTH-1:0]  row_cnt;
  logic                  col_wrap;

  assign pass_eff   = eff_pass(pass_num);
  assign first_beat = (beat_cnt == '0);
  // >= rather than == so a pass_num lowered mid-pixel still closes the pixel.
  assign last_beat  = (beat_cnt >= pass_eff - PASS_WIDTH'(1));
  assign col_wrap   = (col_cnt == col_len);

  // Shared beat counter and pipeline valids
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt <= '0;
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
    end else if (cfg_rst) begin
      beat_cnt <= '0;
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
    end else begin
      s1_vld <= bus.valid_in && last_beat;
      s2_vld <= s1_vld;
      if (bus.valid_in) beat_cnt <= last_beat ? '0 : beat_cnt + PASS_WIDTH'(1);
    end
  end

  // Output stage flags and shared column/row position
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.valid_out <= 1'b0;
      bus.eol_out   <= 1'b0;
      bus.eof_out   <= 1'b0;
      col_cnt       <= '0;
      row_cnt       <= '0;
    end else if (cfg_rst) begin
      bus.valid_out <= 1'b0;
      bus.eol_out   <= 1'b0;
      bus.eof_out   <= 1'b0;
      col_cnt       <= '0;
      row_cnt       <= '0;
    end else begin
      bus.valid_out <= s2_vld;
      bus.eol_out   <= s2_vld && col_wrap;
      bus.eof_out   <= s2_vld && col_wrap && (row_cnt == row_len);
      if (s2_vld) begin
        if (col_wrap) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == row_len) ? '0 : row_cnt + CNT_WIDTH'(1);
        end else begin
          col_cnt <= col_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < CONV_OUT_NUM; g++) begin : g_lane
    logic signed [PSUM_WIDTH-1:0] psum;
    logic signed [BIAS_WIDTH-1:0] bias;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic [DATA_WIDTH-1:0]        dat;

    assign psum = bus.psum_in[g*PSUM_WIDTH +: PSUM_WIDTH];
    assign bias = bias_in[g*BIAS_WIDTH +: BIAS_WIDTH];

    // Holds the running sum; on the final beat it holds the pixel total that
    // stage 2 picks up while the next pixel's first beat reloads it.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)              acc <= '0;
      else if (cfg_rst)       acc <= '0;
      else if (bus.valid_in)  acc <= first_beat ? ACC_WIDTH'(psum) : acc + ACC_WIDTH'(psum);
    end

    conv_requant_lane #(
      .ACC_WIDTH  (ACC_WIDTH),
      .BIAS_WIDTH (BIAS_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rstn    (rstn),
      .s2_en   (s1_vld),
      .s3_en   (s2_vld),
      .acc     (acc),
      .bias    (bias),
      .shift   (shift),
      .relu_en (relu_en),
      .dat     (dat)
    );

    assign bus.data_out[g*DATA_WIDTH +: DATA_WIDTH] = dat;
  end

endmodule

// File: tb/tb_conv_post_process.sv
// Scoreboard bench for conv_post_process: model predicts each pixel at its final beat.
// Latency: expects valid_out exactly 3 cycles after the final beat.
// Backpressure: none exercised; the monitor accepts every output.
module tb_conv_post_process;
  import conv_post_process_pkg::*;

  localparam int N  = 18;
  localparam int PW = 24;
  localparam int BW = 16;
  localparam int DW = 8;
  localparam int CW = 9;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  conv_post_process_if #(.CONV_OUT_NUM(N), .PSUM_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

  logic [N*BW-1:0]        bias_in;
  logic [PASS_WIDTH-1:0]  pass_num;
  logic [SHIFT_WIDTH-1:0] shift;
  logic                   relu_en;
  logic [CW-1:0]          col_len;
  logic [CW-1:0]          row_len;
  logic                   cfg_rst;

  conv_post_process #(
    .CONV_OUT_NUM(N), .PSUM_WIDTH(PW), .ACC_WIDTH(32),
    .BIAS_WIDTH(BW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .bias_in(bias_in), .pass_num(pass_num),
    .shift(shift), .relu_en(relu_en), .col_len(col_len), .row_len(row_len),
    .cfg_rst(cfg_rst)
  );

  typedef struct {
    logic [N*DW-1:0] dat;
    logic            eol;
    logic            eof;
    int              cyc;
    string           tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // model state
  int acc_m[N];
  int psum_m[N];
  int bias_m[N];
  int beat_m = 0;
  int col_m  = 0;
  int row_m  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] requant(input int a, input int b, input int sh, input bit relu);
    longint v;
    longint lo;
    v = longint'(a) + longint'(b);
    if (sh != 0) v = v + (longint'(1) << (sh - 1));
    v  = v >>> sh;
    lo = relu ? 0 : -128;
    if (v > 127) v = 127;
    if (v < lo)  v = lo;
    return 8'(v);
  endfunction

  task automatic set_bias_all(input int b);
    for (int i = 0; i < N; i++) begin
      bias_m[i] = b;
      bias_in[i*BW +: BW] = BW'(b);
    end
  endtask

  task automatic model_clear();
    beat_m = 0; col_m = 0; row_m = 0;
    for (int i = 0; i < N; i++) acc_m[i] = 0;
  endtask

  // Drive one beat from psum_m; valid stays high until idle() is called.
  task automatic drive_beat(input string tag);
    int   pn;
    exp_t e;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) bus.psum_in[i*PW +: PW] = PW'(psum_m[i]);
    bus.valid_in = 1'b1;
    pn = (pass_num == 0) ? 1 : int'(pass_num);
    for (int i = 0; i < N; i++) acc_m[i] = (beat_m == 0) ? psum_m[i] : acc_m[i] + psum_m[i];
    if (beat_m >= pn - 1) begin
      beat_m = 0;
      for (int i = 0; i < N; i++)
        e.dat[i*DW +: DW] = requant(acc_m[i], bias_m[i], int'(shift), relu_en);
      e.eol = (col_m == int'(col_len));
      e.eof = e.eol && (row_m == int'(row_len));
      e.cyc = cyc + 3;
      e.tag = tag;
      sb.push_back(e);
      if (e.eol) begin
        col_m = 0;
        row_m = (row_m == int'(row_len)) ? 0 : row_m + 1;
      end else begin
        col_m = col_m + 1;
      end
    end else begin
      beat_m = beat_m + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
    end
  endtask

  task automatic set_psum(input int base, input int step);
    for (int i = 0; i < N; i++) psum_m[i] = base + i * step;
  endtask

  task automatic drain(input string tag);
    idle(6);
    check({tag, "_drain"}, 256'(sb.size()), 256'(0));
    sb.delete();
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.valid_out) begin
      if (sb.size() == 0) begin
        check("unexpected_valid_out", 256'(1), 256'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_data"},    256'(bus.data_out), 256'(e.dat));
        check({e.tag, "_eol"},     256'(bus.eol_out),  256'(e.eol));
        check({e.tag, "_eof"},     256'(bus.eof_out),  256'(e.eof));
        check({e.tag, "_latency"}, 256'(cyc),          256'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.psum_in = '0; bus.valid_in = 1'b0;
    pass_num = 4'd1; shift = '0; relu_en = 1'b0;
    col_len = '0; row_len = '0; cfg_rst = 1'b0;
    set_bias_all(0);
    model_clear();

    // reset state
    repeat (3) @(negedge clk);
    check("rst_valid_out", 256'(bus.valid_out), 256'(0));
    check("rst_data_out",  256'(bus.data_out),  256'(0));
    check("rst_eol_out",   256'(bus.eol_out),   256'(0));
    check("rst_eof_out",   256'(bus.eof_out),   256'(0));
    @(posedge clk); #1 rstn = 1'b1;

    // Test 1: single pass, all lanes 5, then back-to-back varied lanes
    set_psum(5, 0);
    drive_beat("t1");
    idle(1);
    idle(3);
    set_psum(3, 7);  drive_beat("t1_b2b0");
    set_psum(-50, 3); drive_beat("t1_b2b1");
    idle(1);
    drain("t1");

    // Test 2: three passes with 2-cycle gaps, bias -88, shift 4
    pass_num = 4'd3; shift = 5'd4; set_bias_all(-88);
    set_psum(100, 0); drive_beat("t2"); idle(2);
    set_psum(200, 0); drive_beat("t2"); idle(2);
    set_psum(300, 0); drive_beat("t2"); idle(1);
    drain("t2");

    // Test 3: saturation and ReLU
    pass_num = 4'd1; shift = 5'd2; set_bias_all(0);
    set_psum(-1000, 0); drive_beat("t3_neg"); idle(1);
    drain("t3_neg");
    relu_en = 1'b1;
    set_psum(-1000, 0); drive_beat("t3_relu"); idle(1);
    drain("t3_relu");
    relu_en = 1'b0; shift = 5'd0;
    set_psum(100000, 0); drive_beat("t3_pos"); idle(1);
    drain("t3_pos");

    // Test 4: col/row framing with counters cleared first
    @(posedge clk); #1 cfg_rst = 1'b1;
    @(posedge clk); #1 cfg_rst = 1'b0;
    model_clear();
    col_len = 9'd3; row_len = 9'd1; shift = 5'd1;
    for (int p = 0; p < 9; p++) begin
      set_psum(p * 10, 1);
      drive_beat("t4");
    end
    idle(1);
    drain("t4");

    // Test 5: cfg_rst with a simultaneous beat mid-pixel
    col_len = '0; row_len = '0;
    @(posedge clk); #1 cfg_rst = 1'b1;
    @(posedge clk); #1 cfg_rst = 1'b0;
    model_clear();
    pass_num = 4'd4; shift = 5'd3; set_bias_all(7);
    set_psum(1000, 1); drive_beat("t5_drop");
    set_psum(2000, 1); drive_beat("t5_drop");
    @(posedge clk); #1;
    cfg_rst = 1'b1; bus.valid_in = 1'b1;
    for (int i = 0; i < N; i++) bus.psum_in[i*PW +: PW] = PW'(555);
    model_clear();
    @(posedge clk); #1;
    cfg_rst = 1'b0; bus.valid_in = 1'b0;
    for (int b = 0; b < 4; b++) begin
      set_psum(-300 + b * 111, 5);
      drive_beat("t5_fresh");
    end
    idle(1);
    drain("t5");

    // Random: varied config, pass counts and gaps
    for (int g = 0; g < 4; g++) begin
      pass_num = 4'($urandom_range(1, 5));
      shift    = 5'($urandom_range(0, 12));
      relu_en  = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        bias_m[i] = int'($urandom_range(0, 60000)) - 30000;
        bias_in[i*BW +: BW] = BW'(bias_m[i]);
      end
      for (int p = 0; p < 3 * int'(pass_num); p++) begin
        for (int i = 0; i < N; i++) psum_m[i] = int'($urandom_range(0, 2097152)) - 1048576;
        drive_beat("rnd");
        if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
      end
      idle(1);
      drain("rnd");
    end

    // Test 6: async reset while a pixel sits in stage 2
    pass_num = 4'd1; shift = '0; relu_en = 1'b0; set_bias_all(0);
    set_psum(42, 1); drive_beat("t6_lost");
    @(posedge clk); #1 bus.valid_in = 1'b0;
    @(posedge clk); #1 rstn = 1'b0;
    #1;
    check("t6_rst_valid", 256'(bus.valid_out), 256'(0));
    check("t6_rst_data",  256'(bus.data_out),  256'(0));
    check("t6_rst_eol",   256'(bus.eol_out),   256'(0));
    sb.delete();
    model_clear();
    repeat (3) @(negedge clk);
    check("t6_hold_valid", 256'(bus.valid_out), 256'(0));
    check("t6_hold_data",  256'(bus.data_out),  256'(0));
    @(posedge clk); #1 rstn = 1'b1;
    pass_num = 4'd0;
    set_psum(9, 2);   drive_beat("t6_pass0");
    set_psum(-20, 1); drive_beat("t6_pass0");
    idle(1);
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_post_process.md
CONV_POST_PROCESS -- requirements
Module: conv_post_process

Interface
REQ-001 Parameters SHALL be: CONV_OUT_NUM, default 18, number of output channel lanes.
REQ-002 Parameter PSUM_WIDTH, default 24, SHALL set the signed partial-sum width per lane.
REQ-003 Parameter ACC_WIDTH, default 32, SHALL set the signed accumulator width per lane.
REQ-004 Parameter BIAS_WIDTH, default 16, SHALL set the signed bias width per lane.
REQ-005 Parameter DATA_WIDTH, default 8, SHALL set the signed output activation width.
REQ-006 Parameter CNT_WIDTH, default 9, SHALL set the column/row counter width.
REQ-007 Ports SHALL be: clk  in  1  single clock, rising edge.
REQ-008 rstn  in  1  asynchronous active-low reset.
REQ-009 psum_in  in  CONV_OUT_NUM*PSUM_WIDTH  partial sums, lane 0 in LSBs.
REQ-010 valid_in  in  1  psum_in beat valid.
REQ-011 bias_in  in  CONV_OUT_NUM*BIAS_WIDTH  per-lane bias, static per layer.
REQ-012 pass_num  in  4  input-channel passes per output pixel; 0 is treated as 1.
REQ-013 shift  in  5  requantisation right-shift amount.
REQ-014 relu_en  in  1  enables ReLU clamp.
REQ-015 col_len / row_len  in  CNT_WIDTH each  output columns per row / rows per frame, minus 1.
REQ-016 cfg_rst  in  1  synchronous counter and pipeline clear.
REQ-017 data_out  out  CONV_OUT_NUM*DATA_WIDTH  int8 activations; valid_out  out  1; eol_out  out  1  last pixel of row; eof_out  out  1  last pixel of frame.

Function
REQ-018 The beat counter SHALL advance only on valid_in and hold during gaps.
REQ-019 On the first beat of a pixel, acc SHALL load the sign-extended psum; on later beats it SHALL add it.
REQ-020 Accumulation SHALL be two's complement and wrap at ACC_WIDTH bits without saturation.
REQ-021 On the beat where count equals pass_num-1, the block SHALL issue the pixel to stage 2 and reset the count to 0.
REQ-022 Stage 2 SHALL add the sign-extended bias_in to the final accumulator value.
REQ-023 Stage 3 SHALL apply rounding, arithmetic right shift and, if relu_en, clamping of negatives to 0.
REQ-024 Rounding SHALL add 2^(shift-1) before shifting; when shift is 0, no rounding offset SHALL be added.
REQ-025 Saturation SHALL clamp results to [-128,127]; with relu_en set, the range SHALL be [0,127].
REQ-026 valid_out SHALL assert exactly 3 cycles after the final-beat valid_in and SHALL last 1 cycle per pixel.
REQ-027 Back-to-back pixels SHALL produce back-to-back valid_out; there is no backpressure.
REQ-028 The column counter SHALL increment per output pixel and wrap to 0 after col_len.
REQ-029 The row counter SHALL increment on column wrap and wrap to 0 after row_len.
REQ-030 eol_out SHALL be asserted with valid_out when col equals col_len.
REQ-031 eof_out SHALL be asserted with valid_out when col equals col_len and row equals row_len.
REQ-032 cfg_rst SHALL clear the beat, column and row counters, the accumulators and all pipeline valids on the next edge.
REQ-033 cfg_rst SHALL take priority over a simultaneous valid_in, and that beat SHALL be dropped.
REQ-034 pass_num, shift, relu_en and bias_in SHALL be sampled when the pixel enters stage 2 and stage 3; changes mid-pixel affect only later stages.

Reset
REQ-035 While rstn is low, all counters, accumulators and pipeline registers SHALL be 0.
REQ-036 While rstn is low, data_out, valid_out, eol_out and eof_out SHALL be 0.
REQ-037 Reset assertion mid-pixel SHALL discard that pixel; the first beat after release SHALL be treated as beat 0.

Structure
REQ-038 Widths and the int8 saturation limits SHALL live in the shared conv package/header used by the conv unit.
REQ-039 Per-lane bias-add, round, ReLU and saturate logic SHALL be one sub-module, conv_requant_lane, instantiated CONV_OUT_NUM times.
REQ-040 The beat, column and row counters SHALL be shared across all lanes.

Verification
REQ-041 Test 1: pass_num=1, shift=0, bias=0, lane psum=5 -> data_out lane=5 three cycles later, with valid_out high for 1 cycle.
REQ-042 Test 2: pass_num=3, psums 100, 200, 300 with a 2-cycle gap, bias=-88, shift=4, relu_en=0 -> (512+8)>>4 = 32.
REQ-043 Test 3: psum=-1000, bias=0, shift=2 -> -128 with relu_en=0, and 0 with relu_en=1; psum=+100000, shift=0 -> 127.
REQ-044 Test 4: col_len=3, row_len=1, 8 pixels -> eol_out on pixels 4 and 8; eof_out only on pixel 8; counters wrap and the next pixel has col=0.
REQ-045 Test 5: cfg_rst asserted after beat 2 of pass_num=4, with valid_in high in the same cycle -> no valid_out; the next 4 beats form a fresh pixel with correct sum.
REQ-046 Test 6: rstn pulled low during stage 2 -> outputs are 0 immediately; after release, pass_num=0 behaves as 1.
